// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter (core vs debug/loader) with lock fairness
module dmem_arbiter #(
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [63:0] c_addr,
    input  logic [63:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic        c_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic        d_lock,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata
);

    localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

    logic       last_owner_q, last_owner_d;
    logic       rd_pend_valid_q, rd_pend_valid_d;
    logic       rd_pend_owner_q, rd_pend_owner_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       c_win, d_win;

    // Grants are suppressed while Reset is held so nothing reaches memory.
    always_comb begin
        c_win = 1'b0;
        d_win = 1'b0;
        if (Reset) begin
            if (c_req && d_req) begin
                if (d_lock) begin
                    if (lock_cnt_q < LOCK_LIMIT) d_win = 1'b1;
                    else                         c_win = 1'b1;
                end else if (last_owner_q) begin
                    c_win = 1'b1;
                end else begin
                    d_win = 1'b1;
                end
            end else if (c_req) begin
                c_win = 1'b1;
            end else if (d_req) begin
                d_win = 1'b1;
            end
        end
    end

    always_comb begin
        c_gnt     = c_win;
        d_gnt     = d_win;
        c_stall   = c_req & ~c_win;
        mem_addr  = d_win ? d_addr  : c_addr;
        mem_wdata = d_win ? d_wdata : c_wdata;
        mem_wr    = (c_win & c_we) | (d_win & d_we);
        rdata     = mem_rdata;
        c_rvalid  = rd_pend_valid_q & ~rd_pend_owner_q;
        d_rvalid  = rd_pend_valid_q &  rd_pend_owner_q;
    end

    always_comb begin
        last_owner_d    = last_owner_q;
        rd_pend_valid_d = 1'b0;
        rd_pend_owner_d = rd_pend_owner_q;
        lock_cnt_d      = lock_cnt_q;
        if (c_win || d_win) begin
            last_owner_d    = d_win;
            rd_pend_valid_d = d_win ? ~d_we : ~c_we;
            rd_pend_owner_d = d_win;
        end
        // The lock budget only runs while debug holds lock against a waiting core.
        if (!d_lock || !c_req || c_win) begin
            lock_cnt_d = 8'd0;
        end else if (d_win) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            last_owner_q    <= 1'b1;
            rd_pend_valid_q <= 1'b0;
            rd_pend_owner_q <= 1'b0;
            lock_cnt_q      <= 8'd0;
        end else begin
            last_owner_q    <= last_owner_d;
            rd_pend_valid_q <= rd_pend_valid_d;
            rd_pend_owner_q <= rd_pend_owner_d;
            lock_cnt_q      <= lock_cnt_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int ML = 3;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        c_req, c_we, d_req, d_we, d_lock;
    logic [63:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid, mem_wr;
    logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    string glog, slog, rlog;

    always #5 Clk = ~Clk;

    dmem_arbiter #(.MAX_LOCK(ML)) dut (
        .Clk(Clk), .Reset(Reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_stall(c_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    function automatic logic [63:0] init_word(input int i);
        return (i == 2) ? 64'hDEAD : {32'hA5A5_0000, 32'(i)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_s(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    // Memory environment: one-cycle read latency, write at the closing edge.
    logic [63:0] env_mem [0:63];
    initial begin
        logic [63:0] rd;
        for (int i = 0; i < 64; i++) env_mem[i] = init_word(i);
        mem_rdata = '0;
        forever begin
            @(posedge Clk);
            rd = env_mem[mem_addr[8:3]];
            if (mem_wr) env_mem[mem_addr[8:3]] = mem_wdata;
            mem_rdata <= rd;
        end
    end

    // Reference model: owner history, lock budget and a pending-read scoreboard.
    logic [63:0] ref_mem [0:63];
    int          m_last, m_lock, m_po;
    bit          m_pv;
    logic [63:0] m_pdata;

    function automatic int pick_winner();
        if (c_req && d_req) begin
            if (d_lock) return (m_lock < ML) ? 1 : 0;
            return (m_last == 1) ? 0 : 1;
        end
        if (c_req) return 0;
        if (d_req) return 1;
        return -1;
    endfunction

    initial begin
        int w;
        bit we;
        logic [63:0] a, wd;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        m_last = 1; m_lock = 0; m_pv = 0; m_po = 0; m_pdata = '0;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                m_last = 1; m_lock = 0; m_pv = 0;
                chk("rst_c_gnt", {63'd0, c_gnt}, 64'd0);
                chk("rst_d_gnt", {63'd0, d_gnt}, 64'd0);
                chk("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
                chk("rst_c_rvalid", {63'd0, c_rvalid}, 64'd0);
                chk("rst_d_rvalid", {63'd0, d_rvalid}, 64'd0);
            end else begin
                w = pick_winner();
                we = (w == 1) ? d_we : c_we;
                a  = (w == 1) ? d_addr : c_addr;
                wd = (w == 1) ? d_wdata : c_wdata;
                chk("c_gnt", {63'd0, c_gnt}, {63'd0, w == 0});
                chk("d_gnt", {63'd0, d_gnt}, {63'd0, w == 1});
                chk("c_stall", {63'd0, c_stall}, {63'd0, c_req && w != 0});
                chk("mem_wr", {63'd0, mem_wr}, {63'd0, w >= 0 && we});
                chk("mem_addr", mem_addr, a);
                chk("mem_wdata", mem_wdata, wd);
                chk("c_rvalid", {63'd0, c_rvalid}, {63'd0, m_pv && m_po == 0});
                chk("d_rvalid", {63'd0, d_rvalid}, {63'd0, m_pv && m_po == 1});
                if (m_pv) chk("rdata", rdata, m_pdata);
                m_pv = 0;
                if (w >= 0) begin
                    m_last = w;
                    if (we) ref_mem[a[8:3]] = wd;
                    else begin
                        m_pv = 1; m_po = w; m_pdata = ref_mem[a[8:3]];
                    end
                end
                if (!d_lock || !c_req || w == 0) m_lock = 0;
                else if (w == 1) m_lock++;
            end
        end
    end

    task automatic set_in(input logic cr, input logic cw, input logic [63:0] ca, input logic [63:0] cd,
                          input logic dr, input logic dw, input logic [63:0] da, input logic [63:0] dd,
                          input logic dl);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_lock = dl;
    endtask

    task automatic idle();
        set_in(0, 0, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 0);
    endtask

    task automatic tick();
        @(negedge Clk);
        if (c_gnt) glog = {glog, "C"}; else if (d_gnt) glog = {glog, "D"}; else glog = {glog, "-"};
        if (c_stall) slog = {slog, "1"}; else slog = {slog, "0"};
        if (c_rvalid) rlog = {rlog, "C"}; else if (d_rvalid) rlog = {rlog, "D"}; else rlog = {rlog, "-"};
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b0;
        repeat (2) begin @(posedge Clk); #1; end
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b0;
        idle();
        repeat (2) begin @(posedge Clk); #1; end
        Reset = 1'b1;

        // Core read of 0x10 holding 0xDEAD
        glog = "";
        set_in(1, 0, 64'h10, 64'h0, 0, 0, 64'h0, 64'h0, 0);
        tick();
        idle();
        @(negedge Clk);
        chk("core_rd_rvalid", {63'd0, c_rvalid}, 64'd1);
        chk("core_rd_data", rdata, 64'hDEAD);
        chk("core_rd_d_rvalid", {63'd0, d_rvalid}, 64'd0);
        @(posedge Clk); #1;
        chk_s("core_rd_gnt", glog, "C");

        // Round-robin contention after reset
        do_reset();
        glog = ""; slog = ""; rlog = "";
        set_in(1, 0, 64'h08, 64'h0, 1, 0, 64'h18, 64'h0, 0);
        repeat (4) tick();
        idle();
        tick();
        chk_s("rr_grants", glog, "CDCD-");
        chk_s("rr_stall", slog, "01010");
        chk_s("rr_rvalid", rlog, "-CDCD");

        // Lock with starvation limit
        do_reset();
        glog = "";
        set_in(1, 0, 64'h20, 64'h0, 1, 0, 64'h28, 64'h0, 1);
        repeat (8) tick();
        idle();
        chk_s("lock_grants", glog, "DDDCDDDC");

        // Write then read the same address
        set_in(1, 1, 64'h40, 64'h1234, 0, 0, 64'h0, 64'h0, 0);
        @(negedge Clk);
        chk("wr_mem_wr", {63'd0, mem_wr}, 64'd1);
        chk("wr_mem_addr", mem_addr, 64'h40);
        @(posedge Clk); #1;
        set_in(1, 0, 64'h40, 64'h0, 0, 0, 64'h0, 64'h0, 0);
        @(negedge Clk);
        chk("rd_mem_wr", {63'd0, mem_wr}, 64'd0);
        @(posedge Clk); #1;
        idle();
        @(negedge Clk);
        chk("wr_rd_rvalid", {63'd0, c_rvalid}, 64'd1);
        chk("wr_rd_data", rdata, 64'h1234);
        @(posedge Clk); #1;

        // Reset during an outstanding debug read
        set_in(0, 0, 64'h0, 64'h0, 1, 0, 64'h80, 64'h0, 0);
        @(negedge Clk);
        chk("mid_rd_d_gnt", {63'd0, d_gnt}, 64'd1);
        #2 Reset = 1'b0;
        @(posedge Clk); #1;
        idle();
        @(negedge Clk);
        chk("mid_rd_no_rvalid", {63'd0, d_rvalid}, 64'd0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(negedge Clk);
        chk("post_rst_outs", {59'd0, c_gnt, d_gnt, mem_wr, c_rvalid, d_rvalid}, 64'd0);
        @(posedge Clk); #1;
        glog = "";
        set_in(1, 0, 64'h08, 64'h0, 1, 0, 64'h18, 64'h0, 0);
        tick();
        idle();
        chk_s("post_rst_first", glog, "C");

        // Withdrawn debug request during a core write
        do_reset();
        glog = "";
        set_in(1, 1, 64'h100, 64'h5555, 1, 0, 64'h30, 64'h0, 0);
        tick();
        idle();
        tick();
        set_in(1, 0, 64'h08, 64'h0, 1, 0, 64'h18, 64'h0, 0);
        tick();
        idle();
        chk_s("withdraw", glog, "C-D");

        // Randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                Reset = 1'b0;
            end else begin
                Reset = 1'b1;
            end
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   {55'd0, 6'($urandom_range(0, 63)), 3'd0}, {$urandom, $urandom},
                   $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                   {55'd0, 6'($urandom_range(0, 63)), 3'd0}, {$urandom, $urandom},
                   $urandom_range(0, 2) == 0);
            @(posedge Clk); #1;
        end
        Reset = 1'b1;
        idle();
        repeat (2) begin @(posedge Clk); #1; end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory (Memoria64) between the core datapath and a debug/loader requester. It forwards the winning request to the memory in the same cycle and tracks outstanding reads so that read data returns to the correct owner one cycle later. Lock-based fairness keeps the core from starving. It sits between the control unit/datapath (ALUOut address, RegB write data, MDR load) and the memory.

## Interface
- MAX_LOCK, 8: maximum consecutive debug grants under lock before the core is forced through; range 1..255.
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low; clears all state.
- c_req  input  1  core request; held with address/data until c_gnt.
- c_we  input  1  core write (1) / read (0).
- c_addr  input  64  core byte address.
- c_wdata  input  64  core write data.
- c_gnt  output  1  core request accepted this cycle.
- c_rvalid  output  1  core read data valid on rdata.
- c_stall  output  1  c_req & ~c_gnt; consumed by the control unit to hold its state.
- d_req, d_we, d_addr[63:0], d_wdata[63:0]  input  debug port request, same semantics as the core port.
- d_lock  input  1  debug requests exclusive access while it is high.
- d_gnt, d_rvalid  output  1  debug grant / read valid.
- rdata  output  64  mem_rdata passed through, shared by both ports.
- mem_addr  output  64  memory raddress/waddress.
- mem_wdata  output  64  memory Datain.
- mem_wr  output  1  memory Wr.
- mem_rdata  input  64  memory Dataout; valid the cycle after the address is presented.

## Operation
- Registered state: last_owner (0 = core, 1 = debug), rd_pend (valid, owner), lock_cnt[7:0].
- Arbitration is combinational each cycle. At most one grant is issued per cycle, and a grant is issued only to an asserted req.
- Both ports requesting, no lock: the port not equal to last_owner wins (round-robin). last_owner updates on every grant.
- d_lock=1 with d_req=1 and lock_cnt < MAX_LOCK: debug wins regardless of last_owner. lock_cnt increments on each debug grant while the core is requesting.
- lock_cnt == MAX_LOCK with c_req=1: the core wins that cycle and lock_cnt clears to 0. lock_cnt also clears whenever d_lock=0 or c_req=0.
- Single requester: it wins immediately.
- Granted port drives mem_addr and mem_wdata. mem_wr = gnt & we.
- No grant: mem_wr=0, and mem_addr/mem_wdata hold the core values.
- Read grant: rd_pend <= {1, owner}. Next cycle, the owner's rvalid=1.
- Write grant, or no grant: rd_pend.valid <= 0.
- Reads and writes may issue back to back. Memory order equals grant order, so no hazard logic is required.

## Timing
- Grant latency: 0 cycles when uncontended.
- Read data: mem_rdata is valid on rdata with rvalid exactly 1 cycle after the grant.
- Write: completes at the rising edge closing the grant cycle.
- Reset low, asynchronously and while held: c_gnt=d_gnt=0, mem_wr=0, c_rvalid=d_rvalid=0, last_owner=1 (core wins the first contention), lock_cnt=0, rd_pend.valid=0.
- Reset during an outstanding read: that read never produces rvalid.
- Requester dropping req without a gnt is legal. No state changes.
- c_stall is combinational and deasserts in the cycle c_gnt rises.

## Test plan
- Core read only: c_req=1, c_we=0, c_addr=0x10 with mem holding 0xDEAD at 0x10 -> c_gnt=1 in cycle 0; c_rvalid=1, rdata=0xDEAD in cycle 1; d_rvalid stays 0.
- Contention, round-robin: both ports request reads for 4 cycles, starting after reset -> grant order C, D, C, D; c_stall=1 in cycles 1 and 3; rvalid owners follow one cycle behind the grants.
- Lock with starvation limit, MAX_LOCK=3: d_lock=1, d_req=1, c_req=1 continuously -> grants D, D, D, C, D, D, D, C.
- Write then read the same address: core writes 0x1234 to 0x40, then immediately reads 0x40 -> mem_wr=1 for 1 cycle; the read returns 0x1234 one cycle after its grant.
- Reset mid-read: grant a debug read, then assert Reset low before the next edge -> d_rvalid never asserts; after release, all outputs are 0 and the first contention goes to the core.
- Withdrawn request: d_req pulses for 1 cycle while the core holds the grant with a write -> no d_gnt, and state is unchanged.
